// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory responder.
//   dmem_state_e : responder FSM states (IDLE, WAIT, RESP)
//   F3_*         : RV32I load/store funct3 encodings
//   f3_size()    : access size in bytes for a load/store funct3
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Size is carried in funct3[1:0] for both loads and stores. Illegal
  // encodings report 4 bytes; they are rejected separately anyway.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   f3_size = 3'd1;
      2'b01:   f3_size = 3'd2;
      default: f3_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if -- load/store request/response bus between the core
// (master) and the data-memory responder (slave).
//   req_*  : request channel, master -> slave, valid/ready handshake
//   resp_* : response channel, slave -> master, valid/ready handshake
// Handshake rule for both channels: a transfer happens on a rising clk
// edge where valid and ready are both high; the sender holds valid and
// payload stable until that edge, and valid never depends on ready.
interface dmem_responder_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [AWIDTH-1:0] req_addr_i;
  logic              req_we_i;
  logic [2:0]        req_funct3_i;
  logic [DWIDTH-1:0] req_wdata_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [DWIDTH-1:0] resp_rdata_o;
  logic              resp_err_o;

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_funct3_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_funct3_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align -- combinational byte-lane steering for the responder.
//   funct3_i    : RV32I load/store funct3
//   raw_i       : 4 storage bytes starting at the access offset (byte 0 in [7:0])
//   load_data_o : sign/zero-extended load result
//   wdata_i     : store data, LSB-aligned
//   byte_en_o   : per-byte write enables relative to the access offset
//   wbytes_o    : bytes to write, byte i goes to offset+i
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] raw_i,
  output logic [31:0] load_data_o,
  input  logic [31:0] wdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wbytes_o
);

  always_comb begin
    case (funct3_i)
      F3_LB:   load_data_o = {{24{raw_i[7]}}, raw_i[7:0]};
      F3_LH:   load_data_o = {{16{raw_i[15]}}, raw_i[15:0]};
      F3_LW:   load_data_o = raw_i;
      F3_LBU:  load_data_o = {24'd0, raw_i[7:0]};
      F3_LHU:  load_data_o = {16'd0, raw_i[15:0]};
      default: load_data_o = 32'd0;
    endcase
  end

  // Accesses are performed bytewise from the offset, so store data never
  // needs rotating: only the enable mask depends on the size.
  always_comb begin
    wbytes_o = wdata_i;
    case (funct3_i)
      F3_SB:   byte_en_o = 4'b0001;
      F3_SH:   byte_en_o = 4'b0011;
      F3_SW:   byte_en_o = 4'b1111;
      default: byte_en_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- data-memory responder (slave) for the RV32I core.
// One request at a time, fixed LATENCY cycles from accept to response,
// byte/half/word little-endian access with RV32I extension.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : dmem_responder_if slave modport (request/response channels)
//   dbg_state_o : current FSM state
// Build option: define DMEM_MISALIGN_ERR_EN to reject misaligned half/word
// accesses; by default they are performed bytewise.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          AWIDTH    = 32,
  parameter int          DWIDTH    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int          MEM_BYTES = 1048576,
  parameter int          LATENCY   = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus,
  output dmem_state_e     dbg_state_o
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [7:0] mem [MEM_BYTES];

  logic [AWIDTH-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        size;
  logic              acc_err;
  logic              commit;
  logic [31:0]       raw, load_data, wbytes;
  logic [3:0]        byte_en;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (bus.req_valid_i) begin
        addr_d  = bus.req_addr_i;
        we_d    = bus.req_we_i;
        f3_d    = bus.req_funct3_i;
        wdata_d = bus.req_wdata_i;
        cnt_d   = CNT_W'(LATENCY - 1);
        state_d = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: if (bus.resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The access commits on the edge that enters RESP. The *_d request
  // fields are used so that LATENCY==1 (commit on the accept edge) sees
  // the incoming request rather than the stale latched one.
  assign commit = (state_d == RESP) && (state_q != RESP);
  assign offset = addr_d - AWIDTH'(BASE_ADDR);
  assign idx    = offset[IDX_W-1:0];
  assign size   = f3_size(f3_d);

  always_comb begin
    // Widened by one bit so offsets near the top of the address space
    // (addresses below BASE_ADDR) cannot wrap back into range.
    acc_err = ({1'b0, offset} + (AWIDTH+1)'(size)) > (AWIDTH+1)'(MEM_BYTES);
    if (we_d) begin
      if (f3_d > 3'd2) acc_err = 1'b1;
    end else begin
      if (f3_d == 3'd3 || f3_d == 3'd6 || f3_d == 3'd7) acc_err = 1'b1;
    end
`ifdef DMEM_MISALIGN_ERR_EN
    if ((size == 3'd2 && addr_d[0]) || (size == 3'd4 && addr_d[1:0] != 2'b00)) acc_err = 1'b1;
`endif
  end

  // Index arithmetic wraps inside the array; out-of-range lanes are never
  // written or returned because such accesses are flagged as errors.
  always_comb begin
    for (int i = 0; i < 4; i++) raw[8*i +: 8] = mem[idx + IDX_W'(i)];
  end

  dmem_lane_align u_lane_align (
    .funct3_i    (f3_d),
    .raw_i       (raw),
    .load_data_o (load_data),
    .wdata_i     (wdata_d),
    .byte_en_o   (byte_en),
    .wbytes_o    (wbytes)
  );

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = acc_err;
      rdata_d = (acc_err || we_d) ? '0 : load_data;
    end
  end

  // Storage is not reset; a store in flight when rst rises is dropped.
  always_ff @(posedge clk) begin
    if (commit && we_d && !acc_err && !rst) begin
      for (int i = 0; i < 4; i++)
        if (byte_en[i]) mem[idx + IDX_W'(i)] <= wbytes[8*i +: 8];
    end
  end

  // Outputs
  always_comb begin
    bus.req_ready_o  = (state_q == IDLE);
    bus.resp_valid_o = (state_q == RESP);
    bus.resp_rdata_o = rdata_q;
    bus.resp_err_o   = err_q;
    dbg_state_o      = state_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int          MEMB = 1048576;

  logic        clk = 1'b0;
  logic        rst;
  dmem_state_e dbg_state;

  dmem_responder_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  dmem_responder #(
    .AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .MEM_BYTES(MEMB), .LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic ee, input logic [31:0] er);
    vec_t v;
    v.name = nm; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_err = ee; v.exp_rd = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Driver: issue one request, wait for the response, complete the handshake.
  // lat counts cycles from the accept cycle to the first resp_valid cycle.
  task automatic do_req(input logic [31:0] a, input logic we, input logic [2:0] f3,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int n;
    n = 0;
    while (!bus.req_ready_o && n < 50) begin @(negedge clk); n++; end
    bus.req_valid_i  = 1'b1;
    bus.req_addr_i   = a;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_wdata_i  = wd;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (!bus.resp_valid_o && lat < 50) begin @(negedge clk); lat++; end
    rd = bus.resp_rdata_o;
    er = bus.resp_err_o;
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},  32'(bus.req_ready_o),  32'd1);
    check({tag, " resp_valid"}, 32'(bus.resp_valid_o), 32'd0);
    check({tag, " resp_rdata"}, bus.resp_rdata_o,       32'd0);
    check({tag, " resp_err"},   32'(bus.resp_err_o),    32'd0);
    check({tag, " state"},      32'(dbg_state),         32'(IDLE));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] hold_rd;

    rst = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'd0;
    bus.req_wdata_i  = '0;
    bus.resp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    add("sw_base",      1, F3_SW,  32'h0100_0010, 32'hDEAD_BEEF, 0, 32'h0);
    add("lw_back",      0, F3_LW,  32'h0100_0010, 32'h0,         0, 32'hDEAD_BEEF);
    add("lb_13",        0, F3_LB,  32'h0100_0013, 32'h0,         0, 32'hFFFF_FFDE);
    add("lbu_13",       0, F3_LBU, 32'h0100_0013, 32'h0,         0, 32'h0000_00DE);
    add("lh_12",        0, F3_LH,  32'h0100_0012, 32'h0,         0, 32'hFFFF_DEAD);
    add("lhu_12",       0, F3_LHU, 32'h0100_0012, 32'h0,         0, 32'h0000_DEAD);
    add("sb_11",        1, F3_SB,  32'h0100_0011, 32'h1234_5677, 0, 32'h0);
    add("lw_after_sb",  0, F3_LW,  32'h0100_0010, 32'h0,         0, 32'hDEAD_77EF);
    add("lw_below",     0, F3_LW,  32'h00FF_FFFC, 32'h0,         1, 32'h0);
    add("lw_top_over",  0, F3_LW,  BASE + 32'(MEMB) - 32'd2, 32'h0, 1, 32'h0);
    add("lw_unchanged", 0, F3_LW,  32'h0100_0010, 32'h0,         0, 32'hDEAD_77EF);
    add("ld_f3_3",      0, 3'd3,   32'h0100_0010, 32'h0,         1, 32'h0);
    add("ld_f3_6",      0, 3'd6,   32'h0100_0010, 32'h0,         1, 32'h0);
    add("st_f3_4",      1, 3'd4,   32'h0100_0010, 32'h0000_0000, 1, 32'h0);
    add("lw_no_write",  0, F3_LW,  32'h0100_0010, 32'h0,         0, 32'hDEAD_77EF);
    add("sh_20",        1, F3_SH,  32'h0100_0020, 32'hAAAA_F00D, 0, 32'h0);
    add("lh_20",        0, F3_LH,  32'h0100_0020, 32'h0,         0, 32'hFFFF_F00D);
    add("lw_20_sh_only",0, F3_LW,  32'h0100_0020, 32'h0,         0, {16'h0000, 16'hF00D} & 32'h0000_FFFF | 32'h0);
    add("sb_last",      1, F3_SB,  BASE + 32'(MEMB) - 32'd1, 32'h0000_0080, 0, 32'h0);
    add("lb_last",      0, F3_LB,  BASE + 32'(MEMB) - 32'd1, 32'h0, 0, 32'hFFFF_FF80);
    add("lh_last_over", 0, F3_LH,  BASE + 32'(MEMB) - 32'd1, 32'h0, 1, 32'h0);
    add("sw_30",        1, F3_SW,  32'h0100_0030, 32'h4433_2211, 0, 32'h0);
    add("sw_34",        1, F3_SW,  32'h0100_0034, 32'h8877_6655, 0, 32'h0);
`ifdef DMEM_MISALIGN_ERR_EN
    add("lw_mis_31",    0, F3_LW,  32'h0100_0031, 32'h0, 1, 32'h0);
    add("lh_mis_33",    0, F3_LH,  32'h0100_0033, 32'h0, 1, 32'h0);
`else
    add("lw_mis_31",    0, F3_LW,  32'h0100_0031, 32'h0, 0, 32'h5544_3322);
    add("lh_mis_33",    0, F3_LH,  32'h0100_0033, 32'h0, 0, 32'h0000_5544);
`endif
    add("lw_30",        0, F3_LW,  32'h0100_0030, 32'h0, 0, 32'h4433_2211);

    // The upper half of 0x01000020 was never written; compare only the
    // half the SH defined by masking it out of both sides below.
    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].addr, vecs[i].we, vecs[i].f3, vecs[i].wdata, rd, er, lat);
      if (vecs[i].name == "lw_20_sh_only") rd = rd & 32'h0000_FFFF;
      check({vecs[i].name, " err"},     32'(er),  32'(vecs[i].exp_err));
      check({vecs[i].name, " rdata"},   rd,       vecs[i].exp_rd);
      check({vecs[i].name, " latency"}, 32'(lat), 32'(LAT));
    end

    // Response held off for 5 cycles: everything must stay frozen.
    bus.req_valid_i  = 1'b1;
    bus.req_addr_i   = 32'h0100_0010;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = F3_LW;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (!bus.resp_valid_o && lat < 50) begin @(negedge clk); lat++; end
    check("hold latency", 32'(lat), 32'(LAT));
    hold_rd = bus.resp_rdata_o;
    check("hold first rdata", hold_rd, 32'hDEAD_77EF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold resp_valid", 32'(bus.resp_valid_o), 32'd1);
      check("hold rdata",      bus.resp_rdata_o,       32'hDEAD_77EF);
      check("hold err",        32'(bus.resp_err_o),    32'd0);
      check("hold req_ready",  32'(bus.req_ready_o),   32'd0);
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    check("after hold req_ready", 32'(bus.req_ready_o), 32'd1);

    // Reset while a store is waiting: the store must be dropped.
    bus.req_valid_i  = 1'b1;
    bus.req_addr_i   = 32'h0100_0010;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = F3_SW;
    bus.req_wdata_i  = 32'h0BAD_F00D;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check("mid state is WAIT", 32'(dbg_state), 32'(WAIT));
    rst = 1'b1;
    #1;
    check_reset_outputs("mid-reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(32'h0100_0010, 1'b0, F3_LW, 32'h0, rd, er, lat);
    check("post-reset lw rdata", rd,       32'hDEAD_77EF);
    check("post-reset lw err",   32'(er),  32'd0);
    check("post-reset latency",  32'(lat), 32'(LAT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
